// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core's decoder/ALU and the data-memory responder.
//
// Handshake: MemRead/MemWrite are request levels sampled on the rising edge
// while the responder is idle. An accepted request finishes with a one-cycle
// Ready pulse. ReadData is valid in the Ready cycle of a read and holds that
// value until the next read completes. Stall is high while a read is still
// waiting for the array, and Err pulses for one cycle when a request is
// rejected. The requestor must drop its strobes during the Ready cycle. If a
// strobe is still held when the responder returns to idle, it starts a new
// request. dbgState mirrors the responder FSM for checkers.
interface data_mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Stall;
    logic        Err;
    logic [1:0]  dbgState;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, Ready, Stall, Err, dbgState
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, Ready, Stall, Err, dbgState
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: a word array with a fixed read latency.
// Writes commit on their acceptance edge. A read returns data RD_LAT cycles
// after its acceptance edge.
// Optional feature macro: DMEM_ERR_CHECK_EN. When it is defined, misaligned
// requests and requests with both strobes set are rejected with a one-cycle
// Err pulse.
module data_mem_responder #(
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 2
) (
    input logic clk,
    input logic rst_n,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    logic [31:0]   mem [DEPTH];
    stateT         state;
    logic [3:0]    counter;
    logic [AW-1:0] latchedIdx;
    logic [AW-1:0] idx;
    logic [31:0]   readDataQ;
    logic          readyQ;
    logic          stallQ;
    logic          errQ;
    logic          wrAcc;
    logic          rdAcc;
    logic          reqErr;
    logic          unusedAddr;

    // The upper address bits are dropped, so addresses wrap modulo 4*DEPTH bytes.
    assign idx        = bus.Address[AW+1:2];
    assign unusedAddr = ^{bus.Address[31:AW+2], bus.Address[1:0]};

    // Classify the request seen at this edge. The result only matters in IDLE.
    always_comb begin
        wrAcc  = 1'b0;
        rdAcc  = 1'b0;
        reqErr = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        if (bus.MemRead || bus.MemWrite) begin
            if ((bus.Address[1:0] != 2'b00) || (bus.MemRead && bus.MemWrite)) begin
                reqErr = 1'b1;
            end else begin
                wrAcc = bus.MemWrite;
                rdAcc = bus.MemRead;
            end
        end
`else
        // When both strobes are set, the request is treated as a write.
        wrAcc = bus.MemWrite;
        rdAcc = bus.MemRead && !bus.MemWrite;
`endif
    end

    // Array write port. It has no reset, so data survives a reset of the FSM.
    always_ff @(posedge clk) begin
        if (rst_n && (state == IDLE) && wrAcc) begin
            mem[idx] <= bus.WriteData;
        end
    end

    // Request FSM with registered Ready/Stall/Err/ReadData outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= 4'd0;
            latchedIdx <= '0;
            readDataQ  <= 32'd0;
            readyQ     <= 1'b0;
            stallQ     <= 1'b0;
            errQ       <= 1'b0;
        end else begin
            readyQ <= 1'b0;
            errQ   <= 1'b0;
            case (state)
                IDLE: begin
                    if (wrAcc) begin
                        state  <= RESP;
                        readyQ <= 1'b1;
                    end else if (rdAcc) begin
                        latchedIdx <= idx;
                        if (RD_LAT == 1) begin
                            state     <= RESP;
                            readyQ    <= 1'b1;
                            readDataQ <= mem[idx];
                        end else begin
                            state   <= WAIT;
                            counter <= 4'(RD_LAT - 1);
                            stallQ  <= 1'b1;
                        end
                    end else if (reqErr) begin
                        errQ <= 1'b1;
                    end
                end
                WAIT: begin
                    if (counter == 4'd1) begin
                        state     <= RESP;
                        counter   <= 4'd0;
                        readyQ    <= 1'b1;
                        stallQ    <= 1'b0;
                        readDataQ <= mem[latchedIdx];
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ReadData = readDataQ;
    assign bus.Ready    = readyQ;
    assign bus.Stall    = stallQ;
    assign bus.Err      = errQ;
    assign bus.dbgState = state;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder with DEPTH=64 and RD_LAT=2.
// A table of load/store vectors with hand-computed read data is applied in a
// loop. Hand-written sequences then cover reset, requests during WAIT,
// simultaneous strobes, misaligned addresses and reset during a pending read.
module tb_data_mem_responder;
    localparam int DEPTH  = 64;
    localparam int RD_LAT = 2;

    logic clk;
    logic rst_n;
    int   passCnt;
    int   totalCnt;
    logic [31:0] exp_q[$];

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] data;   // store data, or the expected load data
    } vecT;

    vecT vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic stepc();
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data);
        bus.Address   = addr;
        bus.WriteData = data;
        bus.MemWrite  = 1'b1;
        bus.MemRead   = 1'b0;
        stepc();
        bus.MemWrite = 1'b0;
        chk("wr_ready", {31'd0, bus.Ready}, 32'd1);
        chk("wr_stall", {31'd0, bus.Stall}, 32'd0);
        chk("wr_err", {31'd0, bus.Err}, 32'd0);
        stepc();
        chk("wr_ready_drop", {31'd0, bus.Ready}, 32'd0);
        chk("wr_state_idle", {30'd0, bus.dbgState}, 32'd0);
    endtask

    task automatic doRead(input logic [31:0] addr, input logic [31:0] expData);
        exp_q.push_back(expData);
        bus.Address = addr;
        bus.MemRead = 1'b1;
        bus.MemWrite = 1'b0;
        stepc();
        bus.MemRead = 1'b0;
        for (int i = 1; i < RD_LAT; i++) begin
            chk("rd_stall_wait", {31'd0, bus.Stall}, 32'd1);
            chk("rd_ready_wait", {31'd0, bus.Ready}, 32'd0);
            stepc();
        end
        chk("rd_ready", {31'd0, bus.Ready}, 32'd1);
        chk("rd_stall_resp", {31'd0, bus.Stall}, 32'd0);
        if (exp_q.size() == 0) begin
            totalCnt++;
            $display("FAIL rd_queue: got empty queue expected an entry");
        end else begin
            chk("rd_data", bus.ReadData, exp_q.pop_front());
        end
        stepc();
        chk("rd_ready_drop", {31'd0, bus.Ready}, 32'd0);
    endtask

    initial begin
        passCnt  = 0;
        totalCnt = 0;
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0100, 32'h1234_5678};  // wraps to word 0
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h1234_5678};
        vecs[4]  = '{1'b1, 32'h0000_00FC, 32'h0BAD_F00D};  // last word
        vecs[5]  = '{1'b0, 32'h0000_01FC, 32'h0BAD_F00D};  // wraps to word 63
        vecs[6]  = '{1'b1, 32'h0000_0014, 32'h0000_0001};
        vecs[7]  = '{1'b0, 32'hFFFF_FF10, 32'hDEAD_BEEF};  // upper bits ignored
        vecs[8]  = '{1'b0, 32'h0000_0014, 32'h0000_0001};
        vecs[9]  = '{1'b1, 32'h0000_0020, 32'h1111_1111};
        vecs[10] = '{1'b0, 32'h0000_0020, 32'h1111_1111};

        // Reset
        rst_n         = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Address   = 32'd0;
        bus.WriteData = 32'd0;
        stepc();
        stepc();
        chk("rst_readdata", bus.ReadData, 32'd0);
        chk("rst_ready", {31'd0, bus.Ready}, 32'd0);
        chk("rst_stall", {31'd0, bus.Stall}, 32'd0);
        chk("rst_err", {31'd0, bus.Err}, 32'd0);
        chk("rst_state", {30'd0, bus.dbgState}, 32'd0);
        rst_n = 1'b1;
        stepc();

        // Table-driven load/store vectors
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].isWrite) doWrite(vecs[i].addr, vecs[i].data);
            else doRead(vecs[i].addr, vecs[i].data);
        end

        // Requests during WAIT are ignored and the latched address is kept
        bus.Address = 32'h0000_0010;
        bus.MemRead = 1'b1;
        stepc();
        bus.MemRead   = 1'b0;
        bus.Address   = 32'h0000_0014;
        bus.WriteData = 32'hFFFF_FFFF;
        bus.MemWrite  = 1'b1;
        chk("wait_stall", {31'd0, bus.Stall}, 32'd1);
        chk("wait_state", {30'd0, bus.dbgState}, 32'd1);
        stepc();
        bus.MemWrite = 1'b0;
        chk("wait_ready", {31'd0, bus.Ready}, 32'd1);
        chk("wait_readdata", bus.ReadData, 32'hDEAD_BEEF);
        stepc();
        chk("wait_ready_drop", {31'd0, bus.Ready}, 32'd0);
        doRead(32'h0000_0014, 32'h0000_0001);

        // Simultaneous strobes and misaligned addresses
        bus.Address   = 32'h0000_0020;
        bus.WriteData = 32'hA5A5_A5A5;
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b1;
        stepc();
`ifdef DMEM_ERR_CHECK_EN
        chk("both_err", {31'd0, bus.Err}, 32'd1);
        chk("both_ready", {31'd0, bus.Ready}, 32'd0);
        chk("both_stall", {31'd0, bus.Stall}, 32'd0);
        stepc();
        chk("both_err_again", {31'd0, bus.Err}, 32'd1);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        stepc();
        chk("both_err_drop", {31'd0, bus.Err}, 32'd0);
        doRead(32'h0000_0020, 32'h1111_1111);
        bus.Address = 32'h0000_0013;
        bus.MemRead = 1'b1;
        stepc();
        bus.MemRead = 1'b0;
        chk("misal_err", {31'd0, bus.Err}, 32'd1);
        chk("misal_stall", {31'd0, bus.Stall}, 32'd0);
        chk("misal_ready", {31'd0, bus.Ready}, 32'd0);
        stepc();
        chk("misal_err_drop", {31'd0, bus.Err}, 32'd0);
        chk("misal_state", {30'd0, bus.dbgState}, 32'd0);
`else
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        chk("both_ready", {31'd0, bus.Ready}, 32'd1);
        chk("both_err", {31'd0, bus.Err}, 32'd0);
        stepc();
        doRead(32'h0000_0020, 32'hA5A5_A5A5);
        doRead(32'h0000_0013, 32'hDEAD_BEEF);
        chk("misal_err", {31'd0, bus.Err}, 32'd0);
`endif

        // Reset while a read is pending
        bus.Address = 32'h0000_0000;
        bus.MemRead = 1'b1;
        stepc();
        bus.MemRead = 1'b0;
        chk("prerst_stall", {31'd0, bus.Stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, bus.Stall}, 32'd0);
        chk("midrst_ready", {31'd0, bus.Ready}, 32'd0);
        chk("midrst_readdata", bus.ReadData, 32'd0);
        chk("midrst_state", {30'd0, bus.dbgState}, 32'd0);
        stepc();
        rst_n = 1'b1;
        stepc();
        chk("postrst_state", {30'd0, bus.dbgState}, 32'd0);
        chk("postrst_ready", {31'd0, bus.Ready}, 32'd0);
        doRead(32'h0000_0010, 32'hDEAD_BEEF);
        doRead(32'h0000_0000, 32'h1234_5678);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
